// File: rtl/mlp_host_sequencer.sv
// mlp_host_sequencer: autonomous host-side driver for the mlp slave port.
// Loads inputs and both weight layers, starts the run, waits for completion
// and captures the output register.
module mlp_host_sequencer #(
   parameter int unsigned N_INPUTS       = 2,
   parameter int unsigned N_HIDDEN       = 4,
   parameter int unsigned N_OUTPUT       = 1,
   parameter int unsigned IN_WIDTH       = 16,
   parameter int unsigned WGT_WIDTH      = 16,
   parameter int unsigned OUT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                                                            clk,
   input  logic                                                            rst,
   input  logic                                                            start,
   input  logic [N_INPUTS*IN_WIDTH-1:0]                                    x_in,
   output logic [$clog2(N_HIDDEN*(N_INPUTS+1)+N_OUTPUT*(N_HIDDEN+1))-1:0]  wgt_rd_addr,
   input  logic [WGT_WIDTH-1:0]                                            wgt_rd_data,
   output logic                                                            mlp_write_en,
   output logic [1:0]                                                      mlp_addr,
   output logic [31:0]                                                     mlp_writedata,
   input  logic [31:0]                                                     mlp_readdata,
   input  logic                                                            mlp_irq,
   output logic                                                            busy,
   output logic                                                            done,
   output logic                                                            error,
   output logic [OUT_WIDTH-1:0]                                            result,
   output logic                                                            result_valid
);

   localparam int unsigned N_W1  = N_HIDDEN * (N_INPUTS + 1);
   localparam int unsigned N_W2  = N_OUTPUT * (N_HIDDEN + 1);
   localparam int unsigned WA_W  = $clog2(N_W1 + N_W2);
   localparam int unsigned IDX_W = $clog2(N_INPUTS + N_W1 + N_W2 + 4);
   localparam int unsigned PC_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned X_W   = N_INPUTS * IN_WIDTH;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_LOAD_IN = 4'd1;
   localparam logic [3:0] S_LOAD_W1 = 4'd2;
   localparam logic [3:0] S_SEL_L2  = 4'd3;
   localparam logic [3:0] S_LOAD_W2 = 4'd4;
   localparam logic [3:0] S_RUN     = 4'd5;
   localparam logic [3:0] S_POLL    = 4'd6;
   localparam logic [3:0] S_RDOUT   = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;
   localparam logic [3:0] S_ERR     = 4'd9;

   logic [3:0]           state_q, state_d;
   logic                 phase_q, phase_d;     // 0: setup cycle, 1: strobe cycle
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [WA_W-1:0]      waddr_q, waddr_d;
   logic [PC_W-1:0]      pcnt_q, pcnt_d;
   logic [X_W-1:0]       x_q, x_d;
   logic [IDX_W-1:0]     last_idx;
   logic [3:0]           next_wr_state;

   logic                 we_d, wsel_q, wsel_d, busy_d, done_d, error_d, rv_d;
   logic [1:0]           addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [WA_W-1:0]      rdaddr_d;
   logic [OUT_WIDTH-1:0] result_d;
   logic                 unused_rd;

   assign unused_rd = ^mlp_readdata;

   // Weight writes take ROM data directly in the strobe cycle; others use the staged word.
   assign mlp_writedata = wsel_q ? 32'($signed(wgt_rd_data)) : wdata_q;

   // Next-state sequencing and next-cycle output decode.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      idx_d    = idx_q;
      waddr_d  = waddr_q;
      pcnt_d   = pcnt_q;
      x_d      = x_q;
      result_d = result;
      rv_d     = 1'b0;

      case (state_q)
         S_LOAD_IN: last_idx = IDX_W'(N_INPUTS - 1);
         S_LOAD_W1: last_idx = IDX_W'(N_W1 - 1);
         S_LOAD_W2: last_idx = IDX_W'(N_W2 - 1);
         default:   last_idx = '0;
      endcase

      case (state_q)
         S_LOAD_IN: next_wr_state = S_LOAD_W1;
         S_LOAD_W1: next_wr_state = S_SEL_L2;
         S_SEL_L2:  next_wr_state = S_LOAD_W2;
         S_LOAD_W2: next_wr_state = S_RUN;
         default:   next_wr_state = S_POLL;
      endcase

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LOAD_IN;
               phase_d = 1'b0;
               idx_d   = '0;
               waddr_d = '0;
               x_d     = x_in;
            end
         end
         S_LOAD_IN, S_LOAD_W1, S_SEL_L2, S_LOAD_W2, S_RUN: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (state_q == S_LOAD_W1 || state_q == S_LOAD_W2)
                  waddr_d = waddr_q + WA_W'(1);
               if (idx_q == last_idx) begin
                  state_d = next_wr_state;
                  idx_d   = '0;
                  pcnt_d  = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_POLL: begin
            // DONE bit and irq together still count as one completion.
            if (mlp_readdata[1] || mlp_irq) begin
               state_d = S_RDOUT;
               idx_d   = '0;
            end else if (pcnt_q == PC_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_ERR;
            end else begin
               pcnt_d = pcnt_q + PC_W'(1);
            end
         end
         S_RDOUT: begin
            // idx 0/1: write slot to addr 3, idx 2: capture cycle.
            if (idx_q == IDX_W'(2)) begin
               state_d  = S_DONE;
               result_d = mlp_readdata[OUT_WIDTH-1:0];
               rv_d     = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      we_d     = 1'b0;
      addr_d   = 2'd0;
      wdata_d  = 32'd0;
      wsel_d   = 1'b0;
      rdaddr_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b0;

      case (state_d)
         S_LOAD_IN: begin
            busy_d  = 1'b1;
            we_d    = phase_d;
            addr_d  = 2'd1;
            wdata_d = 32'($signed(x_d[idx_d*IN_WIDTH +: IN_WIDTH]));
         end
         S_LOAD_W1, S_LOAD_W2: begin
            busy_d   = 1'b1;
            we_d     = phase_d;
            addr_d   = 2'd2;
            wsel_d   = 1'b1;
            rdaddr_d = waddr_d;
         end
         S_SEL_L2: begin
            busy_d  = 1'b1;
            we_d    = phase_d;
            wdata_d = 32'h8;
         end
         S_RUN: begin
            busy_d  = 1'b1;
            we_d    = phase_d;
            wdata_d = 32'h1;
         end
         S_POLL:  busy_d = 1'b1;
         S_RDOUT: begin
            busy_d = 1'b1;
            addr_d = 2'd3;
            we_d   = (idx_d == IDX_W'(1));
         end
         S_DONE:  done_d  = 1'b1;
         S_ERR:   error_d = 1'b1;
         default: ;
      endcase
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         phase_q      <= 1'b0;
         idx_q        <= '0;
         waddr_q      <= '0;
         pcnt_q       <= '0;
         x_q          <= '0;
         wsel_q       <= 1'b0;
         wdata_q      <= 32'd0;
         mlp_write_en <= 1'b0;
         mlp_addr     <= 2'd0;
         wgt_rd_addr  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         waddr_q      <= waddr_d;
         pcnt_q       <= pcnt_d;
         x_q          <= x_d;
         wsel_q       <= wsel_d;
         wdata_q      <= wdata_d;
         mlp_write_en <= we_d;
         mlp_addr     <= addr_d;
         wgt_rd_addr  <= rdaddr_d;
         busy         <= busy_d;
         done         <= done_d;
         error        <= error_d;
         result       <= result_d;
         result_valid <= rv_d;
      end
   end

endmodule

// File: tb/tb_mlp_host_sequencer.sv
// Testbench for mlp_host_sequencer: weight ROM + mlp slave model, scoreboard
// of expected bus writes, latency and result checks.
`timescale 1ns/1ps
module tb_mlp_host_sequencer;

   localparam int NI  = 2;
   localparam int NH  = 4;
   localparam int NO  = 1;
   localparam int IW  = 16;
   localparam int WW  = 16;
   localparam int OW  = 16;
   localparam int TMO = 16;
   localparam int NW1 = NH * (NI + 1);
   localparam int NW2 = NO * (NH + 1);
   localparam int NW  = NW1 + NW2;
   localparam int WA  = $clog2(NW);
   localparam int NWR = NI + NW + 2;      // writes before POLL
   localparam int NST = NWR + 1;          // plus the addr-3 write

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [NI*IW-1:0]  x_in = '0;
   logic [WA-1:0]     wgt_rd_addr;
   logic [WW-1:0]     wgt_rd_data = '0;
   logic              mlp_write_en;
   logic [1:0]        mlp_addr;
   logic [31:0]       mlp_writedata;
   logic [31:0]       mlp_readdata;
   logic              mlp_irq;
   logic              busy, done, error, result_valid;
   logic [OW-1:0]     result;

   mlp_host_sequencer #(
      .N_INPUTS(NI), .N_HIDDEN(NH), .N_OUTPUT(NO), .IN_WIDTH(IW),
      .WGT_WIDTH(WW), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .x_in(x_in),
      .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
      .mlp_write_en(mlp_write_en), .mlp_addr(mlp_addr),
      .mlp_writedata(mlp_writedata), .mlp_readdata(mlp_readdata),
      .mlp_irq(mlp_irq), .busy(busy), .done(done), .error(error),
      .result(result), .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // stimulus / slave configuration
   int          xv [NI];
   logic [WW-1:0] rom [NW];
   int          cfg_mode  = 0;   // 0: DONE bit, 1: irq pulse only, 2: never
   int          cfg_delay = 1;
   logic        slave_clr = 1'b0;
   logic        stray_irq = 1'b0;

   // slave state
   int          cyc = 0;
   logic        prev_we = 1'b0;
   int          b2b_err = 0;
   int          in_cnt = 0, w_cnt = 0;
   int          in_arr [NI];
   int          w_arr [NW];
   logic        done_bit = 1'b0, irq_q = 1'b0, running = 1'b0;
   int          run_cnt = 0;
   logic [31:0] out_reg = 32'd0;
   logic [33:0] log_q [$];
   int          log_cyc [$];

   // Reference network: ReLU hidden layer, linear output, per-neuron bias first.
   function automatic logic [31:0] mlp_eval(input int xi [NI], input int w [NW]);
      longint acc, o;
      o = longint'(w[NW1]);
      for (int j = 0; j < NH; j++) begin
         acc = longint'(w[j*(NI+1)]);
         for (int i = 0; i < NI; i++)
            acc += longint'(w[j*(NI+1)+1+i]) * longint'(xi[i]);
         if (acc < 0) acc = 0;
         o += longint'(w[NW1+1+j]) * acc;
      end
      return o[31:0];
   endfunction

   always @(posedge clk) wgt_rd_data <= rom[wgt_rd_addr];

   assign mlp_readdata = (mlp_addr == 2'd0) ? {30'd0, done_bit, 1'b0} :
                         (mlp_addr == 2'd3) ? out_reg : 32'd0;
   assign mlp_irq = irq_q;

   // mlp slave model: records strobes, computes output on RUN, completes after cfg_delay.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      prev_we <= mlp_write_en;
      if (slave_clr) begin
         in_cnt   <= 0;
         w_cnt    <= 0;
         done_bit <= 1'b0;
         irq_q    <= 1'b0;
         running  <= 1'b0;
         b2b_err  <= 0;
         log_q.delete();
         log_cyc.delete();
      end else begin
         irq_q <= stray_irq;
         if (mlp_write_en === 1'b1) begin
            log_q.push_back({mlp_addr, mlp_writedata});
            log_cyc.push_back(cyc);
            if (prev_we) b2b_err <= b2b_err + 1;
            if (mlp_addr == 2'd1 && in_cnt < NI) begin
               in_arr[in_cnt] <= int'($signed(mlp_writedata));
               in_cnt <= in_cnt + 1;
            end
            if (mlp_addr == 2'd2 && w_cnt < NW) begin
               w_arr[w_cnt] <= int'($signed(mlp_writedata));
               w_cnt <= w_cnt + 1;
            end
            if (mlp_addr == 2'd0 && mlp_writedata == 32'h1) begin
               running <= 1'b1;
               run_cnt <= 1;
               out_reg <= mlp_eval(in_arr, w_arr);
            end
         end
         if (running) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt == cfg_delay) begin
               running <= 1'b0;
               if (cfg_mode == 0) done_bit <= 1'b1;
               else if (cfg_mode == 1) irq_q <= 1'b1;
            end
         end
      end
   end

   task automatic arm(input int mode, input int delay);
      cfg_mode  = mode;
      cfg_delay = delay;
      slave_clr = 1'b1;
      @(negedge clk);
      slave_clr = 1'b0;
   endtask

   task automatic drive_x();
      for (int i = 0; i < NI; i++) x_in[i*IW +: IW] = IW'(xv[i]);
   endtask

   // Full inference with scoreboarding of bus writes, latency and result.
   task automatic run_seq(input string name, input int mode, input int delay,
                          input int stray_at, input int start_at);
      int n, bad, fb;
      int xi [NI];
      int wi [NW];
      logic [31:0] model;
      logic [33:0] exp_q [$];
      for (int i = 0; i < NI; i++) xi[i] = xv[i];
      for (int k = 0; k < NW; k++) wi[k] = int'($signed(rom[k]));
      model = mlp_eval(xi, wi);
      for (int i = 0; i < NI; i++) exp_q.push_back({2'd1, 32'(xi[i])});
      for (int k = 0; k < NW1; k++) exp_q.push_back({2'd2, 32'(wi[k])});
      exp_q.push_back({2'd0, 32'h8});
      for (int k = NW1; k < NW; k++) exp_q.push_back({2'd2, 32'(wi[k])});
      exp_q.push_back({2'd0, 32'h1});
      exp_q.push_back({2'd3, 32'h0});

      arm(mode, delay);
      drive_x();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      checks++;
      if ({busy, done, error} !== 3'b100)
         $display("FAIL %s start_accept: busy/done/error=%b expected 100", name, {busy, done, error});
      else passed++;
      while (!done && !error && n < 300) begin
         @(negedge clk);
         n++;
         stray_irq = (n == stray_at);
         start     = (n == start_at);
      end
      start = 1'b0;
      stray_irq = 1'b0;

      checks++;
      if (done !== 1'b1 || n != 46 + delay)
         $display("FAIL %s latency: done=%b after %0d cycles, expected done after %0d", name, done, n, 46 + delay);
      else passed++;
      checks++;
      if (result !== model[OW-1:0] || result_valid !== 1'b1)
         $display("FAIL %s result: got %0d valid=%b, expected %0d valid=1", name, $signed(result), result_valid, $signed(model[OW-1:0]));
      else passed++;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
         $display("FAIL %s post_done: valid=%b done=%b busy=%b, expected 0 1 0", name, result_valid, done, busy);
      else passed++;

      bad = 0; fb = -1;
      for (int k = 0; k < NST && k < log_q.size(); k++)
         if (log_q[k] !== exp_q[k]) begin bad++; if (fb < 0) fb = k; end
      checks++;
      if (log_q.size() != NST || bad != 0) begin
         if (fb >= 0)
            $display("FAIL %s bus_seq: %0d writes, %0d wrong, first #%0d got %h expected %h", name, log_q.size(), bad, fb, log_q[fb], exp_q[fb]);
         else
            $display("FAIL %s bus_seq: %0d writes, expected %0d", name, log_q.size(), NST);
      end else passed++;

      bad = 0;
      for (int k = 1; k < NWR && k < log_cyc.size(); k++)
         if (log_cyc[k] - log_cyc[k-1] != 2) bad++;
      checks++;
      if (bad != 0 || b2b_err != 0)
         $display("FAIL %s strobe_spacing: %0d gaps not 2, %0d back-to-back strobes, expected 0 and 0", name, bad, b2b_err);
      else passed++;
   endtask

   task automatic test_reset();
      for (int k = 0; k < NW; k++) rom[k] = '0;
      for (int i = 0; i < NI; i++) xv[i] = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mlp_write_en, mlp_addr, mlp_writedata, wgt_rd_addr, busy, done, error, result, result_valid} !== '0)
         $display("FAIL reset_outputs: we=%b addr=%0d wd=%h ra=%0d busy=%b done=%b err=%b res=%0d rv=%b, expected all 0",
                  mlp_write_en, mlp_addr, mlp_writedata, wgt_rd_addr, busy, done, error, result, result_valid);
      else passed++;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({mlp_write_en, busy, done, error, result_valid} !== '0)
         $display("FAIL idle_outputs: we=%b busy=%b done=%b err=%b rv=%b, expected 0", mlp_write_en, busy, done, error, result_valid);
      else passed++;
   endtask

   task automatic test_timeout();
      int n;
      arm(2, 0);
      xv[0] = 5; xv[1] = -9;
      drive_x();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!error && !done && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (error !== 1'b1 || n != NWR * 2 + TMO)
         $display("FAIL timeout_latency: error=%b after %0d cycles, expected error after %0d", error, n, NWR * 2 + TMO);
      else passed++;
      checks++;
      if (result !== '0 || busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0)
         $display("FAIL timeout_state: result=%0d busy=%b done=%b rv=%b, expected 0 0 0 0", result, busy, done, result_valid);
      else passed++;
      checks++;
      if (log_q.size() != NWR)
         $display("FAIL timeout_writes: %0d strobes, expected %0d", log_q.size(), NWR);
      else passed++;
   endtask

   task automatic test_directed();
      for (int k = 0; k < NW; k++) rom[k] = '0;
      rom[2]  = 16'd6;       // hidden 0: 6*x[1]
      rom[6]  = 16'h8000;    // hidden 2 bias, clipped by ReLU
      rom[13] = 16'd1;       // output = hidden 0
      xv[0] = -3; xv[1] = 7;
      run_seq("directed", 0, 10, -1, -1);
      checks++;
      if (result !== 16'd42)
         $display("FAIL directed_42: result=%0d expected 42", $signed(result));
      else passed++;
      checks++;
      if (log_q.size() < 9 || log_q[0][31:0] !== 32'hFFFF_FFFD || log_q[8][31:0] !== 32'hFFFF_8000)
         $display("FAIL sign_extend: size=%0d first=%h w6=%h, expected FFFFFFFD FFFF8000",
                  log_q.size(), log_q.size() > 0 ? log_q[0][31:0] : 32'h0, log_q.size() > 8 ? log_q[8][31:0] : 32'h0);
      else passed++;
   endtask

   task automatic test_back_to_back();
      checks++;
      if (done !== 1'b1)
         $display("FAIL pre_restart_done: done=%b expected 1", done);
      else passed++;
      for (int k = 0; k < NW; k++) rom[k] = WW'($urandom_range(0, 40)) - WW'(20);
      xv[0] = 11; xv[1] = -4;
      // stray irq during weight loading, start pulse in POLL
      run_seq("back_to_back", 0, 6, 20, 44);
   endtask

   task automatic test_irq_only();
      xv[0] = 100; xv[1] = 3;
      run_seq("irq_only", 1, 5, -1, -1);
   endtask

   task automatic test_reset_mid_load();
      int n;
      arm(0, 3);
      xv[0] = 2; xv[1] = 9;
      drive_x();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 0; n < 12; n++) @(negedge clk);
      checks++;
      if (wgt_rd_addr !== WA'(4) || mlp_addr !== 2'd2 || mlp_write_en !== 1'b0 || log_q.size() != NI + 4)
         $display("FAIL mid_load_pos: ra=%0d addr=%0d we=%b writes=%0d, expected 4 2 0 %0d",
                  wgt_rd_addr, mlp_addr, mlp_write_en, log_q.size(), NI + 4);
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({mlp_write_en, mlp_addr, mlp_writedata, wgt_rd_addr, busy, done, error, result_valid} !== '0)
         $display("FAIL mid_reset_outputs: we=%b addr=%0d wd=%h ra=%0d busy=%b, expected all 0",
                  mlp_write_en, mlp_addr, mlp_writedata, wgt_rd_addr, busy);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (log_q.size() != NI + 4 || busy !== 1'b0)
         $display("FAIL mid_reset_no_strobe: writes=%0d busy=%b, expected %0d 0", log_q.size(), busy, NI + 4);
      else passed++;
      run_seq("replay", 0, 3, -1, -1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         for (int k = 0; k < NW; k++) rom[k] = WW'($urandom());
         for (int i = 0; i < NI; i++) xv[i] = int'($urandom_range(0, 400)) - 200;
         run_seq($sformatf("random%0d", it), int'($urandom_range(0, 1)), int'($urandom_range(1, 12)), -1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_directed();
      test_back_to_back();
      test_irq_only();
      test_reset_mid_load();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mlp_host_sequencer.md
Name: mlp_host_sequencer

Overview:
- Bus initiator for the mlp accelerator's 4-register slave port (CTRL/INPUT_FIFO/WEIGHT_FIFO/OUTPUT).
- On a start pulse, it performs the full host-side sequence without CPU involvement:
  - pushes the input vector, then hidden-layer weights, then output-layer weights;
  - sets RUN, then polls DONE (or takes irq);
  - reads the output register and presents the result.
- Sits between a weight ROM and the mlp instance.

Parameters:
- N_INPUTS, 2, input vector length
- N_HIDDEN, 4, hidden neurons
- N_OUTPUT, 1, output neurons
- IN_WIDTH, 16, width of each input element
- WGT_WIDTH, 16, weight/bias width
- OUT_WIDTH, 16, result width
- TIMEOUT_CYCLES, 4096, maximum cycles spent in POLL before error

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low: sampled on rising clk edge, active when 0
- start  in  1  one-cycle request to run a full inference; ignored unless in IDLE, DONE or ERR
- x_in  in  N_INPUTS*IN_WIDTH  input vector, element 0 in LSBs; latched on accepted start
- wgt_rd_addr  out  ceil(log2(N_HIDDEN*(N_INPUTS+1)+N_OUTPUT*(N_HIDDEN+1)))  weight ROM address
- wgt_rd_data  in  WGT_WIDTH  weight ROM data, valid 1 cycle after wgt_rd_addr
- mlp_write_en  out  1  slave write strobe
- mlp_addr  out  2  slave register address
- mlp_writedata  out  32  slave write data
- mlp_readdata  in  32  slave read data; combinational on mlp_addr
- mlp_irq  in  1  slave completion interrupt
- busy  out  1  high from accepted start until DONE or ERR
- done  out  1  level, high in DONE state
- error  out  1  level, high in ERR state (poll timeout)
- result  out  OUT_WIDTH  captured output, signed
- result_valid  out  1  one-cycle pulse when result is updated

Behaviour:
- Reset (rst=0 at an edge): state=IDLE.
  - All outputs 0: mlp_write_en=0, mlp_addr=0, mlp_writedata=0, wgt_rd_addr=0, busy=0, done=0, error=0, result=0, result_valid=0.
  - Reset mid-sequence aborts immediately; no further strobes are issued.
- Write slot: every bus write takes exactly 2 cycles.
  - Cycle A: mlp_write_en=0; mlp_addr/mlp_writedata set up; wgt_rd_addr presented when the write is weight-sourced.
  - Cycle B: mlp_write_en=1, data stable.
  - mlp_write_en is never high on two consecutive cycles.
- Write data formatting:
  - Inputs and weights are sign-extended to 32 bits.
  - CTRL writes: 32'h8 selects layer 2 (bit 3); 32'h1 sets RUN (bit 0).
- States:
  - IDLE/DONE/ERR -> LOAD_IN on start. Latch x_in; clear done, error, result_valid; set busy.
  - LOAD_IN: N_INPUTS writes to addr 1, element 0 first.
  - LOAD_W1: N_HIDDEN*(N_INPUTS+1) writes to addr 2 with ROM words 0.. in order. Order is per neuron: bias, then w[0..N_INPUTS-1].
  - SEL_L2: one write, addr 0, data 32'h8.
  - LOAD_W2: N_OUTPUT*(N_HIDDEN+1) writes to addr 2, ROM words continuing from where LOAD_W1 ended. Same per-neuron order.
  - RUN: one write, addr 0, data 32'h1.
  - POLL: mlp_addr=0, mlp_write_en=0, poll counter cleared on entry.
    - Each cycle, exit to RDOUT if mlp_readdata[1]=1 or mlp_irq=1.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, go to ERR.
  - RDOUT: one write slot to addr 3 with data 0, then one cycle with mlp_addr=3, write_en=0.
    - In that cycle: result <= mlp_readdata[OUT_WIDTH-1:0], result_valid=1, next state DONE.
  - DONE: done=1, busy=0, mlp_addr=0.
  - ERR: error=1, busy=0, result unchanged.
- Latency with defaults: 21 writes = 42 cycles, plus poll cycles, plus 3 cycles (RDOUT write slot + capture). Accepted start to done=1 is 45 + P cycles, where P is the number of POLL cycles (≥1).
- Simultaneous events:
  - start while busy is ignored.
  - start in DONE/ERR restarts; the start cycle also clears done/error.
  - mlp_irq and DONE bit asserted together count as a single completion.
  - irq outside POLL is ignored.

Test Plan:
- Defaults; x_in={-3,7}; ROM holds weights that give expected output 42; slave model returns DONE 10 cycles after RUN.
  -> 21 strobes at 2-cycle spacing; addr sequence 1,1,2×12,0(8),2×5,0(1).
  -> result=42 with a one-cycle result_valid; done at cycle 45+P.
- Check first write data: input -3 is written as mlp_writedata=32'hFFFFFFFD. A negative ROM word 16'h8000 is written as 32'hFFFF8000.
- Slave never asserts DONE; TIMEOUT_CYCLES=16.
  -> error=1 exactly 16 POLL cycles after entering POLL; result stays 0; busy=0.
- Completion via mlp_irq only, with readdata[1]=0.
  -> POLL exits on the irq cycle; result captured from addr 3.
- Assert rst=0 during LOAD_W1, at the 5th weight.
  -> next cycle all outputs 0, no strobe; a later start replays the full sequence from ROM word 0.
- start pulsed during POLL -> ignored, sequence unaffected. start in DONE -> done drops next cycle and a new 21-write sequence begins.
